// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with mid-bit sampling, false-start
// rejection and framing-error detection. The rx line is brought into the
// clock domain through a two-flop synchronizer, and every decision is made
// on the synchronized copy (rx_s_q).
//
// Optional feature: define UART_PARITY_EN to expect an even-parity bit
// between data bit 7 and the stop bit. Without that macro there is no
// PARITY state and parity_error is tied low.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       framing_error,
  output logic       parity_error,
  output logic       rx_busy
);

  // Receiver states
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  // Terminal counts: half a bit to reach the start-bit centre, then a
  // full bit between consecutive mid-bit samples.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q;
  logic             rx_s_q;

  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             ready_q,     ready_d;
  logic             ferr_q,      ferr_d;
`ifdef UART_PARITY_EN
  logic             par_bad_q,   par_bad_d;
  logic             perr_q,      perr_d;
`endif

  // Next-state logic: bit timing, sampling and the one-cycle result pulses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            // Line still low at the start-bit centre: a real frame.
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line went back high: a glitch, drop it silently.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = (^shift_q) ^ rx_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
`ifdef UART_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              ready_d = 1'b1;
              data_d  = shift_q;
            end
`else
            ready_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            // A bad stop bit outranks any parity result.
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_HIGH: begin
        // Hold off until the line idles so a break is reported only once.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, synchronizer and output registers; reset discards any frame
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
`ifdef UART_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data       = data_q;
  assign rx_data_ready = ready_q;
  assign framing_error = ferr_q;
  assign rx_busy       = (state_q != S_IDLE);
`ifdef UART_PARITY_EN
  assign parity_error  = perr_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Asynchronous serial receiver for 8N1 frames, with optional even parity.
- Sits directly upstream of the calculator's byte-collecting interface control stage and feeds it one byte per frame.
- Each byte is delivered on rx_data, qualified by a one-cycle rx_data_ready pulse.
- Oversamples the line with a clock-cycle counter, samples mid-bit, rejects false starts and flags framing errors.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); minimum legal value 4.
- CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clock.
- rx_data  output  8  last correctly received byte; holds until the next good frame.
- rx_data_ready  output  1  one-cycle pulse; rx_data valid in the same cycle.
- framing_error  output  1  one-cycle pulse when the stop bit samples low.
- parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_PARITY_EN.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, synchronous and active-high:
  - rx_data=8'h00; rx_data_ready=0; framing_error=0; parity_error=0; rx_busy=0.
  - State=IDLE, counters=0, synchronizer flops=1.
  - Reset has priority over everything, including mid-frame: the frame in progress is discarded and no pulse is emitted.
- Input sync: rx passes through two flops (rx_s); all decisions use rx_s. This adds 2 cycles of latency.
- State machine: IDLE, START, DATA, PARITY (present only with the macro), STOP, WAIT_HIGH.
- IDLE:
  - When rx_s==0, go to START and clear the counter.
- START:
  - Count up to (CLKS_PER_BIT/2)-1 (integer division), then sample rx_s.
  - Sample 0: valid start; go to DATA, clear counter and bit index.
  - Sample 1: glitch; go back to IDLE with no pulse.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into the shift register, LSB first; counter wraps to 0.
  - Bit index runs 0..7. After bit 7, go to PARITY if enabled, else STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - Sample 1, good frame: next cycle rx_data<=shift register and rx_data_ready=1 for exactly one cycle; go to IDLE.
  - Sample 0: framing_error=1 for one cycle; rx_data is unchanged; go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then go to IDLE.
  - A held-low break therefore yields exactly one framing_error, never repeated frames.
- Latency: rx_data_ready rises 1 cycle after the mid-stop-bit sample, i.e. about 9.5 bit times plus 3 cycles after the start-bit falling edge.
- Back-to-back frames: a new start edge seen in IDLE right after the pulse is accepted. There is no dead time beyond the half stop bit.
- Pulse exclusivity: rx_data_ready, framing_error and parity_error are mutually exclusive within a frame. None of them is asserted while in reset.
- No downstream backpressure: the consumer must take rx_data on the pulse. The held value remains readable until the next good frame.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - After data bit 7, the PARITY state waits CLKS_PER_BIT and samples the parity bit.
  - Even parity is expected: XOR of the 8 data bits and the parity bit must equal 0.
  - On mismatch, the frame still completes STOP. At the stop sample:
    - If the stop bit is good, parity_error pulses instead of rx_data_ready and rx_data is not updated.
    - If the stop bit is bad, framing_error takes precedence.
- Undefined: there is no PARITY state, and parity_error is tied to 0.

Test Plan (bench uses CLKS_PER_BIT=16):
- Reset then idle line high for 100 cycles -> all outputs 0, rx_busy=0, no pulses.
- Send 8N1 frame 0x2B (LSB first: 1,1,0,1,0,1,0,0) -> single rx_data_ready pulse with rx_data=8'h2B. The pulse lands 1 cycle after the stop-bit midpoint (±1 cycle), and rx_data holds 8'h2B afterwards.
- Send frames 0x01, 0x05, 0x03 back-to-back with no idle gap -> three pulses delivering 8'h01, 8'h05, 8'h03 in order, matching the op/A/B sequence expected downstream.
- Drive rx low for 5 cycles, then high -> START rejects the glitch and returns to IDLE; no pulses, rx_data unchanged.
- Send 0x55 with the stop bit forced low, then hold rx low for 40 cycles -> exactly one framing_error pulse, rx_data unchanged, rx_busy high until rx returns high. The next good 0xA0 is then received normally.
- Assert reset for 1 cycle during data bit 4 of frame 0xFF -> no pulse; rx_data=8'h00 and state IDLE after reset. With UART_PARITY_EN, 0x07 sent with parity bit 0 -> parity_error pulse; with parity bit 1 -> rx_data_ready and rx_data=8'h07.
